// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the unified memory port arbiter.
//   DEF_ADDR_W / DEF_DATA_W : default address / data widths
//   owner_t                 : which requester owns the read in flight
// ---------------------------------------------------------------------------
package core_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MA   = 2'd2
  } owner_t;

endpackage : core_pkg

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch port, the memory-access port and the external memory bus
// seen by the arbiter.
//   slave  : arbiter view (takes requests, returns grants/read data, drives
//            the memory address/write data, receives data_from_memory)
//   master : requester/memory view, the mirror image of slave
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if
  import core_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  // Fetch stage (read-only)
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  // Memory-access stage (read/write)
  logic              ma_req;
  logic              ma_we;
  logic [ADDR_W-1:0] ma_addr;
  logic [DATA_W-1:0] ma_wdata;
  logic              ma_gnt;
  logic              ma_rvalid;
  logic [DATA_W-1:0] ma_rdata;

  // External memory bus
  logic [ADDR_W-1:0] address_to_memory;
  logic [DATA_W-1:0] data_to_memory;
  logic              data_to_memory_write_en;
  logic [DATA_W-1:0] data_from_memory;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ma_req, ma_we, ma_addr, ma_wdata,
    output ma_gnt, ma_rvalid, ma_rdata,
    output address_to_memory, data_to_memory, data_to_memory_write_en,
    input  data_from_memory
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ma_req, ma_we, ma_addr, ma_wdata,
    input  ma_gnt, ma_rvalid, ma_rdata,
    input  address_to_memory, data_to_memory, data_to_memory_write_en,
    output data_from_memory
  );

endinterface : mem_port_arbiter_if

// File: rtl/mem_port_arbiter_starve_counter.sv
// ---------------------------------------------------------------------------
// arb_starve_counter
// Counts consecutive contested cycles that fetch has lost and raises
// force_if once the count reaches STARVE_MAX, so fetch wins the next
// contested cycle. STARVE_MAX = 0 disables forcing (strict ma priority).
//   clk, rst_n    : clock, asynchronous active-low reset
//   if_gnt        : fetch was granted this cycle (clears the count)
//   ma_win_contest: both requested and ma was granted (advances the count)
//   force_if      : grant fetch if both request this cycle
// ---------------------------------------------------------------------------
module arb_starve_counter
  import core_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_gnt,
  input  logic ma_win_contest,
  output logic force_if
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    starve_cnt_d = starve_cnt_q;
    if (if_gnt) begin
      starve_cnt_d = '0;
    end else if (ma_win_contest && (starve_cnt_q < CNT_MAX)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign force_if = (STARVE_MAX != 0) && (starve_cnt_q == CNT_MAX);

endmodule : arb_starve_counter

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one unified memory port between instruction fetch (read-only) and
// memory access (read/write). One requester is granted per cycle; the owner
// of the read in flight is tracked so the data returning one cycle later is
// routed back to the right stage. Denied requesters stall themselves.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_port_arbiter_if.slave (fetch port, memory-access port,
//                external memory bus)
//   if_stall_cnt / ma_stall_cnt (only with ARB_PERF_CNT_EN defined):
//                saturating counts of cycles each requester waited
// Optional build macro: ARB_PERF_CNT_EN
// ADDR_W/DATA_W must match the parameters of the connected interface.
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]         if_stall_cnt,
  output logic [15:0]         ma_stall_cnt
`endif
);

  logic              force_if;
  logic              if_gnt;
  logic              ma_gnt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  owner_t            owner_q;
  owner_t            owner_d;

  // -------------------------------------------------------------------------
  // Grant: ma wins contention unless fetch has starved long enough. Grants
  // are held off while reset is asserted so nothing reaches the memory.
  // -------------------------------------------------------------------------
  assign if_gnt = rst_n & bus.if_req & (~bus.ma_req | force_if);
  assign ma_gnt = rst_n & bus.ma_req & ~(bus.if_req & force_if);

  assign bus.if_gnt = if_gnt;
  assign bus.ma_gnt = ma_gnt;

  arb_starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_gnt         (if_gnt),
    .ma_win_contest (bus.if_req & bus.ma_req & ma_gnt),
    .force_if       (force_if)
  );

  // -------------------------------------------------------------------------
  // Memory drive. The address register only remembers the last granted
  // address so an idle bus keeps its previous address instead of toggling.
  // -------------------------------------------------------------------------
  always_comb begin
    addr_d    = addr_q;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (if_gnt) begin
      addr_d = bus.if_addr;
    end else if (ma_gnt) begin
      addr_d = bus.ma_addr;
      if (bus.ma_we) begin
        mem_we    = 1'b1;
        mem_wdata = bus.ma_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign bus.address_to_memory       = addr_d;
  assign bus.data_to_memory          = mem_wdata;
  assign bus.data_to_memory_write_en = mem_we;

  // -------------------------------------------------------------------------
  // Read-owner FSM: state register / next state / outputs.
  // Re-evaluated every cycle, so back-to-back reads pipeline with one-cycle
  // latency; a write or an idle cycle leaves no response pending. Reset
  // clears the owner, dropping any read in flight.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (ma_gnt && !bus.ma_we) begin
      owner_d = OWN_MA;
    end
  end

  always_comb begin
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = '0;
    bus.ma_rvalid = 1'b0;
    bus.ma_rdata  = '0;
    case (owner_q)
      OWN_IF: begin
        bus.if_rvalid = 1'b1;
        bus.if_rdata  = bus.data_from_memory;
      end
      OWN_MA: begin
        bus.ma_rvalid = 1'b1;
        bus.ma_rdata  = bus.data_from_memory;
      end
      default: ;
    endcase
  end

`ifdef ARB_PERF_CNT_EN
  // -------------------------------------------------------------------------
  // Stall counters: cycles a requester asked and was not granted, saturating.
  // -------------------------------------------------------------------------
  logic [15:0] if_stall_cnt_q;
  logic [15:0] if_stall_cnt_d;
  logic [15:0] ma_stall_cnt_q;
  logic [15:0] ma_stall_cnt_d;

  always_comb begin
    if_stall_cnt_d = if_stall_cnt_q;
    ma_stall_cnt_d = ma_stall_cnt_q;
    if (bus.if_req && !if_gnt && (if_stall_cnt_q != 16'hFFFF)) begin
      if_stall_cnt_d = if_stall_cnt_q + 16'd1;
    end
    if (bus.ma_req && !ma_gnt && (ma_stall_cnt_q != 16'hFFFF)) begin
      ma_stall_cnt_d = ma_stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_stall_cnt_q <= '0;
      ma_stall_cnt_q <= '0;
    end else begin
      if_stall_cnt_q <= if_stall_cnt_d;
      ma_stall_cnt_q <= ma_stall_cnt_d;
    end
  end

  assign if_stall_cnt = if_stall_cnt_q;
  assign ma_stall_cnt = ma_stall_cnt_q;
`endif

endmodule : mem_port_arbiter
